// File: rtl/tipi_bus_capture_if.sv
// TI data bus / Raspberry Pi signal bundle for the bus capture latch.
// The DUT side uses the slave modport; the master modport is the bus/Pi driver.
`timescale 1ns/1ps
interface tipi_bus_capture_if #(
  parameter int WIDTH = 8
);
  logic             ti_sel;
  logic             ti_we_n;
  logic [WIDTH-1:0] ti_din;
  logic             pi_le;
  logic             pi_sclk;
  logic             pi_sdata;
  logic [WIDTH-1:0] cap_data;
  logic             data_valid;
  logic             overrun;

  modport master (
    output ti_sel, ti_we_n, ti_din, pi_le, pi_sclk,
    input  pi_sdata, cap_data, data_valid, overrun
  );

  modport slave (
    input  ti_sel, ti_we_n, ti_din, pi_le, pi_sclk,
    output pi_sdata, cap_data, data_valid, overrun
  );
endinterface

// File: rtl/tipi_bus_capture.sv
// Receive latch for TI CPU writes: commits a byte at end of write and hands it to the
// Pi in parallel and as an MSB-first serial stream. All async strobes are synchronised.
`timescale 1ns/1ps
module tipi_bus_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  tipi_bus_capture_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    WR,
    COMMIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] we_sync;
  logic [SYNC_STAGES-1:0] sel_sync;
  logic [SYNC_STAGES-1:0] le_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] prime_sync;
  logic                   le_d;
  logic                   sclk_d;
  logic [WIDTH-1:0]       din_r;
  logic [WIDTH-1:0]       hold;
  logic [WIDTH-1:0]       cap_data;
  logic [WIDTH-1:0]       shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   data_valid;
  logic                   overrun;
  logic                   pi_sdata;

  logic we_s, sel_s, le_s, sclk_s, primed;
  logic le_rise, sclk_rise, commit;

  // prime_sync marks when the we_n chain holds live samples rather than its idle reset
  // value, so WAIT_IDLE cannot slip past a write already in progress at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_sync    <= '1;
      sel_sync   <= '0;
      le_sync    <= '0;
      sclk_sync  <= '0;
      prime_sync <= '0;
      le_d       <= 1'b0;
      sclk_d     <= 1'b0;
      din_r      <= '0;
    end else begin
      we_sync    <= {we_sync[SYNC_STAGES-2:0], bus.ti_we_n};
      sel_sync   <= {sel_sync[SYNC_STAGES-2:0], bus.ti_sel};
      le_sync    <= {le_sync[SYNC_STAGES-2:0], bus.pi_le};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], bus.pi_sclk};
      prime_sync <= {prime_sync[SYNC_STAGES-2:0], 1'b1};
      le_d       <= le_s;
      sclk_d     <= sclk_s;
      din_r      <= bus.ti_din;
    end
  end

  assign we_s      = we_sync[SYNC_STAGES-1];
  assign sel_s     = sel_sync[SYNC_STAGES-1];
  assign le_s      = le_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign primed    = prime_sync[SYNC_STAGES-1];
  assign le_rise   = le_s & ~le_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign commit    = (state == COMMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_IDLE;
      hold     <= '0;
      cap_data <= '0;
    end else begin
      case (state)
        WAIT_IDLE: if (primed && we_s) state <= IDLE;
        IDLE:      if (!we_s && sel_s) state <= WR;
        WR: begin
          hold <= din_r;
          if (we_s)        state <= COMMIT;
          else if (!sel_s) state <= IDLE;
        end
        COMMIT: begin
          cap_data <= hold;
          state    <= IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // A load strobe takes cap_data as it stood before any same-cycle commit, and wins
  // over a coincident shift clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      pi_sdata   <= 1'b0;
    end else begin
      if (commit)       data_valid <= 1'b1;
      else if (le_rise) data_valid <= 1'b0;

      if (commit && data_valid && !le_rise) overrun <= 1'b1;
      else if (le_rise)                     overrun <= 1'b0;

      if (le_rise) begin
        shift    <= cap_data;
        bit_cnt  <= '0;
        pi_sdata <= cap_data[WIDTH-1];
      end else if (sclk_rise) begin
        shift    <= {shift[WIDTH-2:0], 1'b0};
        pi_sdata <= (bit_cnt == CNT_MAX) ? 1'b0 : shift[WIDTH-2];
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign bus.cap_data   = cap_data;
  assign bus.data_valid = data_valid;
  assign bus.overrun    = overrun;
  assign bus.pi_sdata   = pi_sdata;

endmodule
